input_conditioner: RTL and testbench
====================================

// Module: input_conditioner
// PURPOSE
//   Multi-channel conditioner for the raw switch/button inputs of the anti-theft system:
//   ignition, brake, hidden switch, driver door, passenger door and reprogram.
//   Each channel gets a 2-FF synchronizer, a counter-based debouncer and a rise/fall edge detector.
//   Sits directly upstream of the alarm FSM, the fuel-pump logic and the parameter bank,
//   which consume clean levels and single-cycle edge pulses.
// PARAMETERS
//   N_CH            6        number of independent input channels
//   DEBOUNCE_CYCLES 1000000  consecutive stable cycles required to accept a change (>=1; 10 ms @100 MHz)
//   CNT_W           20       counter width; must hold DEBOUNCE_CYCLES+1
// PORTS
//   clock    in   1      system clock, rising-edge
//   reset    in   1      asynchronous, active-low reset
//   noisy    in   N_CH   raw asynchronous switch inputs
//   clean    out  N_CH   debounced stable levels
//   rise     out  N_CH   1-cycle pulse when clean[i] goes 0->1
//   fall     out  N_CH   1-cycle pulse when clean[i] goes 1->0
//   changed  out  1      OR-reduction of (rise | fall)
//   valid    out  1      0 until start-up settling completes, then 1 until next reset
// BEHAVIOUR
//   Reset (reset=0, async):
//   - All flops clear immediately, independent of clock.
//   - sync stages=0, counters=0, clean=0, rise=fall=0, changed=0, valid=0.
//   - Reset mid-debounce discards partial counts; no pulse is emitted.
//   Synchronizer:
//   - s1[i] <= noisy[i]; s2[i] <= s1[i].
//   - Only s2 is used downstream.
//   Debounce, per channel, independent:
//   - s2[i]==clean[i]: cnt[i] <= 0. Any glitch restarts the count.
//   - s2[i]!=clean[i] and cnt[i] < DEBOUNCE_CYCLES-1: cnt[i] <= cnt[i]+1.
//   - s2[i]!=clean[i] and cnt[i]==DEBOUNCE_CYCLES-1: clean[i] <= s2[i], cnt[i] <= 0.
//   - cnt never exceeds DEBOUNCE_CYCLES-1 and never wraps.
//   Latency:
//   - A noisy change first sampled at edge 1, held stable, updates clean at edge DEBOUNCE_CYCLES+2.
//   - DEBOUNCE_CYCLES=1 gives 3-edge latency with no filtering beyond the synchronizer.
//   Filtering:
//   - Changes stable for fewer than DEBOUNCE_CYCLES cycles at s2 never reach clean.
//   Edges:
//   - rise/fall are registered: high exactly 1 cycle, starting at the edge where clean updates.
//   - changed is registered alongside them, same cycle.
//   Start-up:
//   - Separate counter holds valid=0 for DEBOUNCE_CYCLES+2 edges after reset release, then valid=1.
//   - While valid=0, clean updates normally, but rise/fall/changed are forced 0.
//   Simultaneous events:
//   - Channels are fully independent; any combination of rise/fall bits may assert in one cycle.
//   - changed stays a single 1-cycle pulse.
//   Constraint: no combinational path from noisy to any output.
// TESTING (bench uses DEBOUNCE_CYCLES=4, N_CH=6)
//   1. Hold reset=0 with noisy=6'h3F, release, keep noisy.
//      -> clean=0, valid=0 during reset.
//      -> clean=6'h3F at edge 6 after release; valid=1 at edge 6.
//      -> rise/fall/changed stay 0 throughout.
//   2. After valid=1, noisy[0] 0->1 and held.
//      -> clean[0]=1 at 6th sampling edge.
//      -> rise[0]=1 and changed=1 for exactly 1 cycle; no other bits pulse.
//   3. noisy[2] pulses high for 3 cycles, then returns low.
//      -> clean[2] stays 0; no rise/fall/changed.
//   4. noisy[4] toggles every 2 cycles for 20 cycles, then settles at 1.
//      -> exactly one rise[4], 6 edges after the final transition is sampled.
//   5. noisy[1] 0->1 and noisy[3] 1->0 in the same cycle.
//      -> rise[1] and fall[3] assert in the same cycle.
//      -> changed is high for one cycle only.
//   6. noisy[5] changes; assert reset=0 asynchronously (between edges) when cnt[5]=3.
//      -> all outputs 0 immediately, no pulse.
//      -> after release, clean[5] updates only after a full 6-edge interval.

Source files
------------

// File: rtl/input_conditioner_if.sv
// Bundles the raw switch inputs and the conditioned outputs of the input conditioner.
interface input_conditioner_if #(
    parameter int N_CH = 6
);
    logic [N_CH-1:0] noisy;
    logic [N_CH-1:0] clean;
    logic [N_CH-1:0] rise;
    logic [N_CH-1:0] fall;
    logic            changed;
    logic            valid;

    // Producer of raw inputs / consumer of conditioned levels and pulses
    modport master (
        output noisy,
        input  clean,
        input  rise,
        input  fall,
        input  changed,
        input  valid
    );

    // The conditioner itself
    modport slave (
        input  noisy,
        output clean,
        output rise,
        output fall,
        output changed,
        output valid
    );
endinterface

// File: rtl/input_conditioner.sv
// Multi-channel switch conditioner: per channel a 2-FF synchronizer, a counter
// debouncer and registered rise/fall pulse generation, plus a start-up settling
// counter that holds valid low and masks pulses until the debouncers have settled.
// Every output comes straight from a flop, so there is no combinational path from
// the raw inputs to any output.
module input_conditioner #(
    parameter int N_CH            = 6,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = 20
) (
    input  logic             clock,
    input  logic             reset,
    input_conditioner_if.slave bus
);

    // Last count value before a change is accepted, and last start-up count.
    localparam logic [CNT_W-1:0] CNT_LAST     = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] STARTUP_LAST = CNT_W'(DEBOUNCE_CYCLES + 1);

    logic [N_CH-1:0]  s1_q;
    logic [N_CH-1:0]  s2_q;
    logic [N_CH-1:0]  clean_q, clean_d;
    logic [N_CH-1:0]  rise_q, rise_d;
    logic [N_CH-1:0]  fall_q, fall_d;
    logic             changed_q, changed_d;
    logic             valid_q, valid_d;
    logic [CNT_W-1:0] cnt_q [N_CH];
    logic [CNT_W-1:0] cnt_d [N_CH];
    logic [CNT_W-1:0] st_cnt_q, st_cnt_d;

    // Two-stage synchronizer; only s2 feeds the debouncers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= bus.noisy;
            s2_q <= s1_q;
        end
    end

    // Per-channel debounce: count consecutive cycles where s2 disagrees with the
    // accepted level; any agreement restarts the count. The edge pulse is produced
    // in the same cycle the level is accepted, masked until start-up completes.
    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            cnt_d[i]   = cnt_q[i];
            clean_d[i] = clean_q[i];
            rise_d[i]  = 1'b0;
            fall_d[i]  = 1'b0;
            if (s2_q[i] == clean_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_LAST) begin
                cnt_d[i]   = '0;
                clean_d[i] = s2_q[i];
                rise_d[i]  = valid_q & s2_q[i];
                fall_d[i]  = valid_q & ~s2_q[i];
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
        changed_d = |(rise_d | fall_d);
    end

    // Start-up settling: valid rises on the (DEBOUNCE_CYCLES+2)-th edge after
    // reset release and then stays high; the counter freezes once valid is set.
    always_comb begin
        st_cnt_d = st_cnt_q;
        valid_d  = valid_q;
        if (!valid_q) begin
            if (st_cnt_q == STARTUP_LAST) begin
                valid_d = 1'b1;
            end else begin
                st_cnt_d = st_cnt_q + CNT_W'(1);
            end
        end
    end

    // Debounce, edge and start-up state; reset discards any partial count.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < N_CH; i++) begin
                cnt_q[i] <= '0;
            end
            clean_q   <= '0;
            rise_q    <= '0;
            fall_q    <= '0;
            changed_q <= 1'b0;
            valid_q   <= 1'b0;
            st_cnt_q  <= '0;
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            clean_q   <= clean_d;
            rise_q    <= rise_d;
            fall_q    <= fall_d;
            changed_q <= changed_d;
            valid_q   <= valid_d;
            st_cnt_q  <= st_cnt_d;
        end
    end

    assign bus.clean   = clean_q;
    assign bus.rise    = rise_q;
    assign bus.fall    = fall_q;
    assign bus.changed = changed_q;
    assign bus.valid   = valid_q;

endmodule

// File: tb/tb_input_conditioner.sv
// Bench for input_conditioner: directed scenarios followed by random switch
// activity, checked cycle by cycle against a sliding-window reference model.
module tb_input_conditioner;

    localparam int N = 6;
    localparam int D = 4;

    typedef struct packed {
        logic [N-1:0] clean;
        logic [N-1:0] rise;
        logic [N-1:0] fall;
        logic         changed;
        logic         valid;
    } exp_t;

    logic clock = 1'b0;
    logic reset = 1'b0;

    input_conditioner_if #(.N_CH(N)) bus ();

    input_conditioner #(
        .N_CH            (N),
        .DEBOUNCE_CYCLES (D),
        .CNT_W           (20)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    exp_t exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Reference model: noisy samples taken at each edge are kept in a queue.
    // The synchronized value seen before edge t is the sample of edge t-2, and a
    // channel's level flips at edge t when the D synchronized values before it
    // (samples of edges t-2 .. t-D-1) all differ from the accepted level.
    logic [N-1:0] samp[$];
    logic [N-1:0] m_clean;
    int           edges;

    always @(posedge clock) begin
        exp_t         e;
        logic [N-1:0] r, f;
        logic         vb, all_diff;
        e = '0;
        if (!reset) begin
            samp.delete();
            for (int k = 0; k <= D; k++) samp.push_back('0);
            m_clean = '0;
            edges   = 0;
        end else begin
            r  = '0;
            f  = '0;
            vb = (edges >= D + 2);
            for (int i = 0; i < N; i++) begin
                all_diff = 1'b1;
                for (int k = 1; k <= D; k++)
                    if (samp[k][i] == m_clean[i]) all_diff = 1'b0;
                if (all_diff) begin
                    m_clean[i] = ~m_clean[i];
                    if (vb) begin
                        if (m_clean[i]) r[i] = 1'b1;
                        else            f[i] = 1'b1;
                    end
                end
            end
            if (edges < D + 2) edges++;
            samp.push_front(bus.noisy);
            void'(samp.pop_back());
            e.clean   = m_clean;
            e.rise    = r;
            e.fall    = f;
            e.changed = |(r | f);
            e.valid   = (edges >= D + 2);
        end
        exp_q.push_back(e);
    end

    // Monitor: the DUT presents a full output word every cycle.
    always @(negedge clock) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("clean",   32'(bus.clean),   32'(e.clean));
            chk("rise",    32'(bus.rise),    32'(e.rise));
            chk("fall",    32'(bus.fall),    32'(e.fall));
            chk("changed", 32'(bus.changed), 32'(e.changed));
            chk("valid",   32'(bus.valid),   32'(e.valid));
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clock);
    endtask

    initial begin
        // 1: start-up with all inputs high
        bus.noisy = 6'h3F;
        reset     = 1'b0;
        cyc(4);
        reset = 1'b1;
        cyc(5);
        chk("startup_clean_e5", 32'(bus.clean), 32'h0);
        chk("startup_valid_e5", 32'(bus.valid), 32'h0);
        cyc(1);
        chk("startup_clean_e6", 32'(bus.clean), 32'h3F);
        chk("startup_valid_e6", 32'(bus.valid), 32'h1);
        cyc(4);

        // all channels fall together
        bus.noisy = 6'h00;
        cyc(10);

        // 2: single rise on channel 0
        bus.noisy[0] = 1'b1;
        cyc(10);

        // 3: short pulse on channel 2 must be filtered
        bus.noisy[2] = 1'b1;
        cyc(3);
        bus.noisy[2] = 1'b0;
        cyc(10);

        // 4: bouncing channel 4, then settle high
        for (int t = 0; t < 10; t++) begin
            bus.noisy[4] = ~bus.noisy[4];
            cyc(2);
        end
        bus.noisy[4] = 1'b1;
        cyc(10);

        // 5: simultaneous rise on 1 and fall on 3
        bus.noisy[3] = 1'b1;
        cyc(10);
        bus.noisy[1] = 1'b1;
        bus.noisy[3] = 1'b0;
        cyc(10);

        // 6: asynchronous reset in the middle of a debounce on channel 5
        bus.noisy[5] = 1'b1;
        cyc(5);
        #2 reset = 1'b0;
        #1;
        chk("async_clean",   32'(bus.clean),   32'h0);
        chk("async_rise",    32'(bus.rise),    32'h0);
        chk("async_fall",    32'(bus.fall),    32'h0);
        chk("async_changed", 32'(bus.changed), 32'h0);
        chk("async_valid",   32'(bus.valid),   32'h0);
        cyc(3);
        reset = 1'b1;
        cyc(5);
        chk("rerelease_clean_e5", 32'(bus.clean), 32'h0);
        cyc(1);
        chk("rerelease_clean_e6", 32'(bus.clean), 32'(bus.noisy));
        cyc(4);

        // random switch activity with occasional quiet stretches
        for (int t = 0; t < 800; t++) begin
            for (int i = 0; i < N; i++)
                if ($urandom_range(0, 7) == 0) bus.noisy[i] = ~bus.noisy[i];
            if ($urandom_range(0, 31) == 0) cyc(D + 4);
            else                            cyc(1);
        end
        cyc(12);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
